// File: rtl/hazard_pkg.sv
// Shared types, forwarding-select codes and Tnew lookup for the D-stage hazard controller.
package hazard_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned CLS_W  = 3;
    localparam int unsigned FSEL_W = 3;
    localparam int unsigned TUSE_W = 2;

    typedef enum logic [CLS_W-1:0] {
        CLS_NONE = 3'd0,
        CLS_LINK = 3'd1,
        CLS_ALU  = 3'd2,
        CLS_MDR  = 3'd3,
        CLS_LOAD = 3'd4
    } cls_e;

    typedef enum logic [1:0] {
        STG_E = 2'd0,
        STG_M = 2'd1,
        STG_W = 2'd2
    } stage_e;

    localparam logic [FSEL_W-1:0] FSEL_PC8_E = 3'b000;
    localparam logic [FSEL_W-1:0] FSEL_PC8_M = 3'b001;
    localparam logic [FSEL_W-1:0] FSEL_ALU_M = 3'b010;
    localparam logic [FSEL_W-1:0] FSEL_MD_M  = 3'b011;
    localparam logic [FSEL_W-1:0] FSEL_RES_W = 3'b100;
    localparam logic [FSEL_W-1:0] FSEL_RF    = 3'b111;

    localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dst;
        cls_e             cls;
    } stage_rec_t;

    typedef struct packed {
        logic              stall;
        logic [FSEL_W-1:0] fsel;
    } fwd_t;

    localparam stage_rec_t REC_BUBBLE = '{valid: 1'b0, dst: '0, cls: CLS_NONE};

    // Cycles until a producer in the given stage has its result available.
    function automatic logic [TUSE_W-1:0] tnew(input cls_e cls, input stage_e stg);
        logic [TUSE_W-1:0] t;
        t = 2'd0;
        case (stg)
            STG_E: begin
                case (cls)
                    CLS_ALU:  t = 2'd1;
                    CLS_MDR:  t = 2'd1;
                    CLS_LOAD: t = 2'd2;
                    default:  t = 2'd0;
                endcase
            end
            STG_M:   t = (cls == CLS_LOAD) ? 2'd1 : 2'd0;
            default: t = 2'd0;
        endcase
        return t;
    endfunction

    // Forwarding select and stall for one D-stage operand; youngest matching stage wins.
    function automatic fwd_t operand_check(input logic [REG_W-1:0] src, input logic [TUSE_W-1:0] tuse,
                                           input stage_rec_t e, input stage_rec_t m, input stage_rec_t w);
        fwd_t r;
        r.stall = 1'b0;
        r.fsel  = FSEL_RF;
        if (src != '0) begin
            if (e.valid && (e.dst == src)) begin
                r.stall = (tnew(e.cls, STG_E) > tuse);
                if (e.cls == CLS_LINK) r.fsel = FSEL_PC8_E;
            end else if (m.valid && (m.dst == src)) begin
                r.stall = (tnew(m.cls, STG_M) > tuse);
                case (m.cls)
                    CLS_LINK: r.fsel = FSEL_PC8_M;
                    CLS_ALU:  r.fsel = FSEL_ALU_M;
                    CLS_MDR:  r.fsel = FSEL_MD_M;
                    default:  r.fsel = FSEL_RF;
                endcase
            end else if (w.valid && (w.dst == src)) begin
                r.fsel = FSEL_RES_W;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage operand/producer description in, forwarding selects and stall out.
interface hazard_ctrl_if;
    import hazard_pkg::*;

    logic [REG_W-1:0]  rs_D;
    logic [REG_W-1:0]  rt_D;
    logic [TUSE_W-1:0] tuse_rs_D;
    logic [TUSE_W-1:0] tuse_rt_D;
    logic [REG_W-1:0]  wr_D;
    logic [CLS_W-1:0]  cls_D;
    logic              md_start_D;
    logic              md_div_D;
    logic              md_use_D;
    logic [FSEL_W-1:0] fsel1_D;
    logic [FSEL_W-1:0] fsel2_D;
    logic              stall;
    logic              md_busy;

    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, wr_D, cls_D, md_start_D, md_div_D, md_use_D,
        input  fsel1_D, fsel2_D, stall, md_busy
    );

    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, wr_D, cls_D, md_start_D, md_div_D, md_use_D,
        output fsel1_D, fsel2_D, stall, md_busy
    );
endinterface

// File: rtl/md_busy_counter.sv
// Multiply/divide busy counter: loads on issue into E, counts down to zero.
module md_busy_counter #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_div,
    output logic o_busy
);
    localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] r_count;

    // A load always beats the decrement; otherwise saturate at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_busy = (r_count != '0);
endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: E/M/W producer tracking, forwarding selects, stall, MDU busy.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);
    stage_rec_t r_e;
    stage_rec_t r_m;
    stage_rec_t r_w;
    logic       r_e_md;

    fwd_t w_rs;
    fwd_t w_rt;
    logic w_md_busy;
    logic w_md_stall;
    logic w_stall;
    logic w_md_load;

    // Per-operand hazard decisions, purely from the stage records and D inputs.
    always_comb begin
        w_rs = operand_check(hz.rs_D, hz.tuse_rs_D, r_e, r_m, r_w);
        w_rt = operand_check(hz.rt_D, hz.tuse_rt_D, r_e, r_m, r_w);
    end

    // HI/LO users wait while the MDU counts or an md op has just entered E.
    assign w_md_stall = hz.md_use_D & (w_md_busy | (r_e.valid & r_e_md));
    assign w_stall    = w_rs.stall | w_rt.stall | w_md_stall;
    assign w_md_load  = hz.md_start_D & ~w_stall;

    assign hz.fsel1_D = w_rs.fsel;
    assign hz.fsel2_D = w_rt.fsel;
    assign hz.stall   = w_stall;
    assign hz.md_busy = w_md_busy;

    // Pipeline advance; a stall injects a bubble into E while M and W keep moving.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_e    <= REC_BUBBLE;
            r_m    <= REC_BUBBLE;
            r_w    <= REC_BUBBLE;
            r_e_md <= 1'b0;
        end else begin
            r_w <= r_m;
            r_m <= r_e;
            if (w_stall) begin
                r_e    <= REC_BUBBLE;
                r_e_md <= 1'b0;
            end else begin
                r_e    <= '{valid: 1'b1, dst: hz.wr_D, cls: cls_e'(hz.cls_D)};
                r_e_md <= hz.md_start_D;
            end
        end
    end

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_counter (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_md_load),
        .i_div  (hz.md_div_D),
        .o_busy (w_md_busy)
    );
endmodule
